// File: rtl/led_chaser_pkg.sv
// Shared constants for the LED chaser: pattern-select codes and ping-pong direction.
package led_chaser_pkg;

  localparam logic [1:0] MODE_ROT_L = 2'd0;
  localparam logic [1:0] MODE_ROT_R = 2'd1;
  localparam logic [1:0] MODE_PING  = 2'd2;
  localparam logic [1:0] MODE_FILL  = 2'd3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level signal already synchronous to clk.
// The history flop resets to 1 so a level that is high when reset releases
// is not mistaken for a fresh edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic tick_q;

  // Track the previous-cycle level of the input.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= 1'b1;
    end else begin
      tick_q <= level;
    end
  end

  assign rise = level & ~tick_q;

endmodule

// File: rtl/led_chaser.sv
// LED chaser: advances a WIDTH-bit pattern on each accepted rising edge of
// the divider tick, through rotate-left, rotate-right, ping-pong or bar fill.
// A mode change seen at a step reloads the new mode's start value instead of
// advancing, so the pattern never leaves a legal sequence.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic [1:0]       mode,
  input  logic             pause,
  output logic [WIDTH-1:0] led,
  output logic             step_pulse,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LED_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] LED_MSB  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LED_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] LED_ALL  = {WIDTH{1'b1}};

  logic             rise;
  logic             step;
  logic [1:0]       mode_q;
  dir_t             dir;
  dir_t             dir_next;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] led_next;
  logic             wrap_next;

  rise_detect u_rise_detect (
    .clk   (clk),
    .reset (reset),
    .level (tick_in),
    .rise  (rise)
  );

  // A pause only masks the step; edge history keeps tracking underneath.
  assign step = rise & ~pause;

  // Start value of the requested mode, used when the mode changes at a step.
  always_comb begin
    start_val = LED_ONE;
    case (mode)
      MODE_ROT_R: start_val = LED_MSB;
      MODE_FILL:  start_val = LED_ZERO;
      default:    start_val = LED_ONE;
    endcase
  end

  // Next pattern, next ping-pong direction and wrap flag for the current mode.
  always_comb begin
    led_next  = led;
    dir_next  = dir;
    wrap_next = 1'b0;
    if (mode != mode_q) begin
      led_next  = start_val;
      dir_next  = DIR_UP;
      wrap_next = 1'b0;
    end else begin
      case (mode_q)
        MODE_ROT_L: begin
          led_next  = {led[WIDTH-2:0], led[WIDTH-1]};
          wrap_next = led[WIDTH-1];
        end
        MODE_ROT_R: begin
          led_next  = {led[0], led[WIDTH-1:1]};
          wrap_next = led[0];
        end
        MODE_PING: begin
          case (dir)
            DIR_UP: begin
              led_next = {led[WIDTH-2:0], 1'b0};
              // Turn around on the same step that lands on the MSB.
              if (led[WIDTH-2]) begin
                dir_next = DIR_DOWN;
              end else begin
                dir_next = DIR_UP;
              end
            end
            DIR_DOWN: begin
              led_next = {1'b0, led[WIDTH-1:1]};
              // Landing back on bit0 completes one full period.
              if (led[1]) begin
                dir_next  = DIR_UP;
                wrap_next = 1'b1;
              end else begin
                dir_next  = DIR_DOWN;
                wrap_next = 1'b0;
              end
            end
            default: begin
              led_next = LED_ONE;
              dir_next = DIR_UP;
            end
          endcase
        end
        MODE_FILL: begin
          if (led == LED_ALL) begin
            led_next  = LED_ZERO;
            wrap_next = 1'b1;
          end else begin
            led_next  = {led[WIDTH-2:0], 1'b1};
            wrap_next = 1'b0;
          end
        end
        default: begin
          led_next  = LED_ONE;
          wrap_next = 1'b0;
        end
      endcase
    end
  end

  // Ping-pong direction state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir <= DIR_UP;
    end else if (step) begin
      dir <= dir_next;
    end
  end

  // Pattern, latched mode and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      led        <= LED_ONE;
      mode_q     <= MODE_ROT_L;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      step_pulse <= step;
      wrap       <= step & wrap_next;
      if (step) begin
        led    <= led_next;
        mode_q <= mode;
      end
    end
  end

endmodule

// File: tb/tb_led_chaser.sv
// Scoreboard bench for led_chaser: each driven cycle pushes the expected
// post-edge outputs from a position-based reference model; the entry is
// popped and compared once the DUT has updated.
module tb_led_chaser;

  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick_in;
  logic [1:0]    mode;
  logic          pause;
  logic [TW-1:0] led;
  logic          step_pulse;
  logic          wrap;

  typedef struct packed {
    logic [TW-1:0] e_led;
    logic          e_sp;
    logic          e_wr;
    logic          e_dir;
    logic [1:0]    e_mode;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;
  int wraps_seen  = 0;
  int steps_seen  = 0;

  // Reference model state: lit position (or fill count), direction, mode, edge history.
  int         m_pos = 0;
  logic       m_dir = 1'b0;
  logic [1:0] m_mode = 2'd0;
  logic       m_tq = 1'b1;

  led_chaser #(.WIDTH(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_in    (tick_in),
    .mode       (mode),
    .pause      (pause),
    .led        (led),
    .step_pulse (step_pulse),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] model_led();
    logic [31:0] v;
    v = 32'd1 << m_pos;
    if (m_mode == 2'd3) v = v - 32'd1;
    return v[TW-1:0];
  endfunction

  task automatic model_step(input logic r, input logic t, input logic p,
                            input logic [1:0] m, output exp_t e);
    logic rs;
    logic sp;
    logic wr;
    sp = 1'b0;
    wr = 1'b0;
    if (r) begin
      m_pos  = 0;
      m_dir  = 1'b0;
      m_mode = 2'd0;
      m_tq   = 1'b1;
    end else begin
      rs   = t && !m_tq;
      m_tq = t;
      sp   = rs && !p;
      if (sp) begin
        if (m != m_mode) begin
          m_mode = m;
          m_dir  = 1'b0;
          m_pos  = (m == 2'd1) ? TW - 1 : 0;
        end else begin
          case (m_mode)
            2'd0: begin m_pos = (m_pos + 1) % TW; wr = (m_pos == 0); end
            2'd1: begin m_pos = (m_pos + TW - 1) % TW; wr = (m_pos == TW - 1); end
            2'd2: begin
              if (!m_dir) begin
                m_pos++;
                if (m_pos == TW - 1) m_dir = 1'b1;
              end else begin
                m_pos--;
                if (m_pos == 0) begin m_dir = 1'b0; wr = 1'b1; end
              end
            end
            default: begin
              if (m_pos == TW) begin m_pos = 0; wr = 1'b1; end
              else m_pos++;
            end
          endcase
        end
      end
    end
    e.e_led  = model_led();
    e.e_sp   = sp;
    e.e_wr   = wr;
    e.e_dir  = m_dir;
    e.e_mode = m_mode;
  endtask

  task automatic cycle(input logic r, input logic t, input logic p, input logic [1:0] m);
    exp_t e;
    exp_t x;
    reset   = r;
    tick_in = t;
    pause   = p;
    mode    = m;
    model_step(r, t, p, m, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check_val("led",        32'(led),         32'(x.e_led));
    check_val("step_pulse", 32'(step_pulse),  32'(x.e_sp));
    check_val("wrap",       32'(wrap),        32'(x.e_wr));
    check_val("dir",        32'(dut.dir),     32'(x.e_dir));
    check_val("mode_q",     32'(dut.mode_q),  32'(x.e_mode));
    if (wrap) wraps_seen++;
    if (step_pulse) steps_seen++;
  endtask

  task automatic hold(input int n, input logic r, input logic t, input logic p, input logic [1:0] m);
    for (int i = 0; i < n; i++) cycle(r, t, p, m);
  endtask

  task automatic rises(input int k, input int half, input logic p, input logic [1:0] m);
    for (int i = 0; i < k; i++) begin
      hold(half, 1'b0, 1'b0, p, m);
      hold(half, 1'b0, 1'b1, p, m);
    end
  endtask

  initial begin
    int s0;
    int w0;
    logic [1:0] mcur;
    logic rr;
    logic tt;
    logic pp;

    // Tick high through reset release: no step for 50 cycles.
    hold(3, 1'b1, 1'b1, 1'b0, 2'd0);
    check_val("reset_led", 32'(led), 32'h01);
    s0 = steps_seen;
    hold(50, 1'b0, 1'b1, 1'b0, 2'd0);
    check_val("high_no_step", 32'(steps_seen - s0), 32'd0);
    check_val("high_led", 32'(led), 32'h01);

    // Rotate-left, 9 rises with a 20-cycle half period.
    w0 = wraps_seen;
    rises(9, 20, 1'b0, 2'd0);
    check_val("rotl_led", 32'(led), 32'h02);
    check_val("rotl_wraps", 32'(wraps_seen - w0), 32'd1);

    // Ping-pong: one reload rise, then 15 steps.
    hold(2, 1'b1, 1'b0, 1'b0, 2'd0);
    rises(1, 3, 1'b0, 2'd2);
    check_val("ping_reload", 32'(led), 32'h01);
    w0 = wraps_seen;
    rises(7, 3, 1'b0, 2'd2);
    check_val("ping_top", 32'(led), 32'h80);
    check_val("ping_dir_down", 32'(dut.dir), 32'd1);
    rises(8, 3, 1'b0, 2'd2);
    check_val("ping_led", 32'(led), 32'h02);
    check_val("ping_wraps", 32'(wraps_seen - w0), 32'd1);

    // Bar fill: reload to 00 at the mode-change rise, then 9 steps.
    w0 = wraps_seen;
    rises(1, 3, 1'b0, 2'd3);
    check_val("fill_reload", 32'(led), 32'h00);
    check_val("fill_reload_wrap", 32'(wraps_seen - w0), 32'd0);
    rises(8, 3, 1'b0, 2'd3);
    check_val("fill_full", 32'(led), 32'hFF);
    rises(1, 3, 1'b0, 2'd3);
    check_val("fill_clear", 32'(led), 32'h00);
    check_val("fill_wraps", 32'(wraps_seen - w0), 32'd1);

    // Rotate-right with pause: edges lost, re-enable while high gives no step.
    rises(1, 3, 1'b0, 2'd1);
    check_val("rotr_reload", 32'(led), 32'h80);
    s0 = steps_seen;
    rises(3, 3, 1'b1, 2'd1);
    check_val("pause_led", 32'(led), 32'h80);
    hold(5, 1'b0, 1'b1, 1'b0, 2'd1);
    check_val("pause_no_step", 32'(steps_seen - s0), 32'd0);
    rises(1, 3, 1'b0, 2'd1);
    check_val("rotr_after_pause", 32'(led), 32'h40);

    // Reset coincident with a rise while led = 20 in rotate-left.
    rises(6, 3, 1'b0, 2'd0);
    check_val("pre_reset_led", 32'(led), 32'h20);
    hold(3, 1'b0, 1'b0, 1'b0, 2'd0);
    cycle(1'b1, 1'b1, 1'b0, 2'd0);
    check_val("rst_rise_led", 32'(led), 32'h01);
    check_val("rst_rise_sp", 32'(step_pulse), 32'd0);
    check_val("rst_rise_mode", 32'(dut.mode_q), 32'd0);
    hold(2, 1'b0, 1'b0, 1'b0, 2'd0);

    // Randomised traffic against the model.
    mcur = 2'd0;
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 59) == 0);
      tt = 1'($urandom_range(0, 1));
      pp = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) mcur = 2'($urandom_range(0, 3));
      cycle(rr, tt, pp, mcur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
